// File: rtl/aes_decipher_if.sv
// Control, data and key-memory signals shared between the AES decipher engine and its user.
interface aes_decipher_if;
    logic         start;
    logic         abort;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic [127:0] new_block;
    logic         ready;
    logic         done;
    logic         err;

    modport master (
        output start, abort, keylen, block, round_key,
        input  round, new_block, ready, done, err
    );

    modport slave (
        input  start, abort, keylen, block, round_key,
        output round, new_block, ready, done, err
    );
endinterface

// File: rtl/aes_decipher_engine.sv
// Iterative AES-128/192/256 inverse-cipher round engine with SBOX_WORDS inverse S-box lanes.
// The round keys come from an external key memory indexed by the round output.
module aes_decipher_engine #(
    parameter int unsigned SBOX_WORDS = 1
) (
    input logic           clk,
    input logic           reset_n,
    aes_decipher_if.slave dif
);
    localparam int unsigned S = 4 / SBOX_WORDS;

    if (!(SBOX_WORDS == 1 || SBOX_WORDS == 2 || SBOX_WORDS == 4)) begin : g_bad_sbox_words
        $error("SBOX_WORDS must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StInit, StSbox, StMain} state_e;

    state_e       st_q;
    logic [3:0]   round_ctr_q;
    logic [1:0]   word_ctr_q;
    logic [1:0]   keylen_q;
    logic [127:0] state_q;
    logic         ready_q;
    logic         done_q;
    logic         err_q;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
        return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
    endfunction

    // Row r of column c takes the byte from column c-r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c - r + 4) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
            };
        end
        return o;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'd0:    return 4'd10;
            2'd1:    return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    logic [1:0]   lane_idx [SBOX_WORDS];
    logic [31:0]  lane_out [SBOX_WORDS];
    logic [127:0] sbox_state;
    logic         last_sbox;
    logic [3:0]   nr_latched;

    // Word k*SBOX_WORDS+l lives at bit offset 32*(3-idx), i.e. {~idx, 5'b0}.
    for (genvar l = 0; l < int'(SBOX_WORDS); l++) begin : g_lane
        assign lane_idx[l] = 2'(32'(word_ctr_q) * SBOX_WORDS + 32'(l));
        assign lane_out[l] = inv_sub_word(state_q[{~lane_idx[l], 5'd0} +: 32]);
    end

    always_comb begin
        sbox_state = state_q;
        for (int l = 0; l < int'(SBOX_WORDS); l++) begin
            sbox_state[{~lane_idx[l], 5'd0} +: 32] = lane_out[l];
        end
    end

    assign last_sbox  = (word_ctr_q == 2'(S - 1));
    assign nr_latched = nr_of(keylen_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= StIdle;
            round_ctr_q <= 4'd0;
            word_ctr_q  <= 2'd0;
            keylen_q    <= 2'd0;
            state_q     <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (dif.abort && st_q != StIdle) begin
                st_q    <= StIdle;
                ready_q <= 1'b1;
            end else begin
                unique case (st_q)
                    StIdle: begin
                        if (dif.start) begin
                            if (dif.keylen == 2'd3) begin
                                err_q <= 1'b1;
                            end else begin
                                keylen_q    <= dif.keylen;
                                round_ctr_q <= nr_of(dif.keylen);
                                ready_q     <= 1'b0;
                                st_q        <= StInit;
                            end
                        end
                    end
                    StInit: begin
                        state_q    <= inv_shift_rows(dif.block ^ dif.round_key);
                        word_ctr_q <= 2'd0;
                        st_q       <= StSbox;
                    end
                    StSbox: begin
                        state_q <= sbox_state;
                        if (last_sbox) begin
                            round_ctr_q <= round_ctr_q - 4'd1;
                            word_ctr_q  <= 2'd0;
                            st_q        <= StMain;
                        end else begin
                            word_ctr_q <= word_ctr_q + 2'd1;
                        end
                    end
                    StMain: begin
                        if (round_ctr_q != 4'd0) begin
                            state_q    <= inv_shift_rows(inv_mix_columns(state_q ^ dif.round_key));
                            word_ctr_q <= 2'd0;
                            st_q       <= StSbox;
                        end else begin
                            state_q <= state_q ^ dif.round_key;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            st_q    <= StIdle;
                        end
                    end
                    default: st_q <= StIdle;
                endcase
            end
        end
    end

    // The round counter never exceeds the Nr of the key length latched at start.
    assert property (@(posedge clk) disable iff (!reset_n)
        (st_q != StIdle) |-> (round_ctr_q <= nr_latched));

    assign dif.round     = round_ctr_q;
    assign dif.new_block = state_q;
    assign dif.ready     = ready_q;
    assign dif.done      = done_q;
    assign dif.err       = err_q;
endmodule

// File: tb/tb_aes_decipher_engine.sv
// Directed bench for aes_decipher_engine: three instances (SBOX_WORDS 1, 2, 4) share stimulus.
module tb_aes_decipher_engine;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                       64'h0};
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, abort;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [127:0] rk_mem [15];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    aes_decipher_if dif0 ();
    aes_decipher_if dif1 ();
    aes_decipher_if dif2 ();

    assign dif0.start = start, dif0.abort = abort, dif0.keylen = keylen, dif0.block = block;
    assign dif1.start = start, dif1.abort = abort, dif1.keylen = keylen, dif1.block = block;
    assign dif2.start = start, dif2.abort = abort, dif2.keylen = keylen, dif2.block = block;
    assign dif0.round_key = rk_mem[dif0.round];
    assign dif1.round_key = rk_mem[dif1.round];
    assign dif2.round_key = rk_mem[dif2.round];

    // Instance d has S = 4 >> d S-box cycles per round.
    aes_decipher_engine #(.SBOX_WORDS(1)) dut0 (.clk(clk), .reset_n(reset_n), .dif(dif0));
    aes_decipher_engine #(.SBOX_WORDS(2)) dut1 (.clk(clk), .reset_n(reset_n), .dif(dif1));
    aes_decipher_engine #(.SBOX_WORDS(4)) dut2 (.clk(clk), .reset_n(reset_n), .dif(dif2));

    logic [2:0]   rdy_v, dn_v, er_v;
    logic [3:0]   rnd_v [3];
    logic [127:0] nb_v  [3];
    assign rdy_v = {dif2.ready, dif1.ready, dif0.ready};
    assign dn_v  = {dif2.done, dif1.done, dif0.done};
    assign er_v  = {dif2.err, dif1.err, dif0.err};
    assign rnd_v[0] = dif0.round, rnd_v[1] = dif1.round, rnd_v[2] = dif2.round;
    assign nb_v[0] = dif0.new_block, nb_v[1] = dif1.new_block, nb_v[2] = dif2.new_block;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        for (int c = 1; c < 256; c++) if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One decipher on all three instances: latency, round sequence and plaintext.
    task automatic run_op(input string tag, input logic [1:0] kl, input logic [255:0] key,
                          input logic [127:0] ct, input int nk, input logic [1:0] kl_after,
                          input bit pokes);
        int lat [3];
        bit seen [3];
        int rbad = 0;
        int nr = nk + 6;
        int m, s, exp_r;
        expand_key(key, nk);
        lat = '{default: -1};
        seen = '{default: 1'b0};
        block = ct; keylen = kl; start = 1'b1;
        tick();
        start = 1'b0; keylen = kl_after;
        chk({tag, " busy"}, rdy_v, 3'b000);
        chk({tag, " round0"}, {rnd_v[0], rnd_v[1], rnd_v[2]}, {3{4'(nr)}});
        for (int k = 1; k <= 400 && !(seen[0] && seen[1] && seen[2]); k++) begin
            if (pokes) start = (k == 3 || k == 8);
            tick();
            for (int d = 0; d < 3; d++) begin
                if (!seen[d]) begin
                    s = 4 >> d;
                    m = k - 1;
                    exp_r = nr - m / (s + 1) - (((m % (s + 1)) == s) ? 1 : 0);
                    if (rnd_v[d] != exp_r[3:0]) rbad++;
                    if (dn_v[d]) begin
                        seen[d] = 1'b1;
                        lat[d]  = k;
                    end
                end
            end
        end
        start = 1'b0;
        chk({tag, " round seq"}, 128'(rbad), 128'd0);
        tick();
        chk({tag, " done pulse"}, dn_v, 3'b000);
        chk({tag, " ready back"}, rdy_v, 3'b111);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s lat sbw%0d", tag, 1 << d), 128'(lat[d]),
                128'(1 + nr * ((4 >> d) + 1)));
            chk($sformatf("%s pt sbw%0d", tag, 1 << d), nb_v[d], PT);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1 [3];
        int d2 [3];
        logic [127:0] nb2 [3];

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; keylen = 2'd0; block = '0;
        expand_key(KEY128, 4);
        #12;
        chk("reset ready", rdy_v, 3'b111);
        chk("reset done/err", {dn_v, er_v}, 6'b0);
        chk("reset round", {rnd_v[0], rnd_v[1], rnd_v[2]}, 12'h0);
        chk("reset new_block", nb_v[0] | nb_v[1] | nb_v[2], 128'h0);
        reset_n = 1'b1;
        tick();

        run_op("aes128", 2'd0, KEY128, CT128, 4, 2'd0, 1'b0);
        run_op("aes192 pokes", 2'd1, KEY192, CT192, 6, 2'd1, 1'b1);
        run_op("aes256", 2'd2, KEY256, CT256, 8, 2'd2, 1'b0);
        run_op("keylen latch", 2'd0, KEY128, CT128, 4, 2'd2, 1'b0);

        // Reserved key length: rejected with a one-cycle err, engine stays idle.
        keylen = 2'd3; start = 1'b1;
        tick();
        start = 1'b0; keylen = 2'd0;
        chk("rsvd err", er_v, 3'b111);
        chk("rsvd ready", rdy_v, 3'b111);
        chk("rsvd round", {rnd_v[0], rnd_v[1], rnd_v[2]}, 12'h0);
        tick();
        chk("rsvd err pulse", er_v, 3'b000);
        chk("rsvd still idle", rdy_v, 3'b111);
        run_op("after rsvd", 2'd0, KEY128, CT128, 4, 2'd0, 1'b0);

        // Abort in the fifth S-box cycle of the SBOX_WORDS=1 instance.
        expand_key(KEY128, 4);
        block = CT128; keylen = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort ready", rdy_v, 3'b111);
        chk("abort no done", dn_v, 3'b000);
        run_op("after abort", 2'd2, KEY256, CT256, 8, 2'd2, 1'b0);

        // Back-to-back: start held high across the done cycle.
        expand_key(KEY128, 4);
        d1 = '{default: -1};
        d2 = '{default: -1};
        block = CT128; keylen = 2'd0; start = 1'b1;
        for (int t = 0; t < 300 && (d2[0] < 0 || d2[1] < 0 || d2[2] < 0); t++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (dn_v[d]) begin
                    if (d1[d] < 0) begin
                        d1[d] = t;
                    end else if (d2[d] < 0) begin
                        d2[d]  = t;
                        nb2[d] = nb_v[d];
                    end
                end
            end
        end
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("b2b first sbw%0d", 1 << d), 128'(d1[d]), 128'(10 * ((4 >> d) + 1) + 1));
            chk($sformatf("b2b gap sbw%0d", 1 << d), 128'(d2[d] - d1[d]),
                128'(10 * ((4 >> d) + 1) + 2));
            chk($sformatf("b2b pt sbw%0d", 1 << d), nb2[d], PT);
        end
        for (int t = 0; t < 200 && rdy_v != 3'b111; t++) tick();
        chk("b2b drain", rdy_v, 3'b111);

        // Asynchronous reset in the middle of an AES-256 operation.
        expand_key(KEY256, 8);
        block = CT256; keylen = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("midrst ready", rdy_v, 3'b111);
        chk("midrst done/err", {dn_v, er_v}, 6'b0);
        chk("midrst round", {rnd_v[0], rnd_v[1], rnd_v[2]}, 12'h0);
        chk("midrst new_block", nb_v[0] | nb_v[1] | nb_v[2], 128'h0);
        #2 reset_n = 1'b1;
        run_op("after reset", 2'd1, KEY192, CT192, 6, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
